// File: rtl/ram64_arbiter.sv
// ram64_arbiter: zero-fill sweep after reset, then round-robin sharing of one RAM64 between two ports
module ram64_arbiter #(
   parameter int WIDTH          = 16,
   parameter int ADDR_W         = 6,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [WIDTH-1:0]  wdata0,
   input  logic [WIDTH-1:0]  wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [WIDTH-1:0]  rdata0,
   output logic [WIDTH-1:0]  rdata1,
   output logic              busy,
   output logic [WIDTH-1:0]  ram_in,
   output logic              ram_load,
   output logic [ADDR_W-1:0] ram_address,
   input  logic [WIDTH-1:0]  ram_out
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   typedef enum logic {CLEAR, ARB} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              last_q;
   logic [WIDTH-1:0]  rdata0_q, rdata1_q;
   logic              g0, g1;
   // when both ask, the port that was not granted last wins
   assign g0 = req0 & (~req1 | last_q);
   assign g1 = req1 & (~req0 | ~last_q);
   assign rdata0 = rdata0_q;
   assign rdata1 = rdata1_q;
   // sweep sequencing, grant qualification and RAM port steering; reset masks all activity
   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      ack0        = 1'b0;
      ack1        = 1'b0;
      busy        = 1'b0;
      ram_address = addr0;
      ram_in      = '0;
      ram_load    = 1'b0;
      if (state_q == CLEAR) begin
         busy        = 1'b1;
         ram_address = clr_cnt_q;
         ram_load    = 1'b1;
         clr_cnt_d   = clr_cnt_q + 1'b1;
         state_d     = (clr_cnt_q == LAST_ADDR) ? ARB : CLEAR;
      end else begin
         ack0        = g0;
         ack1        = g1;
         ram_address = g1 ? addr1 : addr0;
         ram_in      = g0 ? wdata0 : (g1 ? wdata1 : '0);
         ram_load    = (g0 & we0) | (g1 & we1);
      end
      if (reset) begin
         ack0     = 1'b0;
         ack1     = 1'b0;
         ram_load = 1'b0;
         busy     = CLEAR_ON_RESET;
      end
   end
   // state, sweep counter, round-robin history and per-port read capture
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q   <= CLEAR_ON_RESET ? CLEAR : ARB;
         clr_cnt_q <= '0;
         last_q    <= 1'b1;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         if (ack0) begin
            last_q <= 1'b0;
            if (!we0) rdata0_q <= ram_out;
         end
         if (ack1) begin
            last_q <= 1'b1;
            if (!we1) rdata1_q <= ram_out;
         end
      end
   end
endmodule

// File: tb/tb_ram64_arbiter.sv
// tb_ram64_arbiter: RAM model plus reference-model, table and directed checks of ram64_arbiter
module tb_ram64_arbiter;
   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [5:0]  addr0 = '0, addr1 = '0;
   logic [15:0] wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1, busy, ram_load;
   logic [15:0] rdata0, rdata1, ram_in, ram_out;
   logic [5:0]  ram_address;
   logic [15:0] ram [64];
   logic        seeded = 1'b0;
   int          errors = 0;
   int          checks = 0;
   int          m_clr;
   logic        m_last;
   logic [15:0] m_rd0, m_rd1;
   logic [15:0] ref_mem [64];
   logic        s_ack0, s_ack1;
   logic        p0 = 1'b0, p1 = 1'b0, pw0, pw1, rr;
   logic [5:0]  pa0, pa1;
   logic [15:0] pd0, pd1;
   int          i0;
   typedef struct {
      logic r0, w0; logic [5:0] a0; logic [15:0] d0;
      logic r1, w1; logic [5:0] a1; logic [15:0] d1;
      logic x0, x1; logic [15:0] q0, q1;
   } vec_t;
   vec_t tbl [10];

   ram64_arbiter dut (
      .CLK(CLK), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
      .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
   );

   always #5 CLK = ~CLK;

   // RAM64: garbage contents at power-up so the clear sweep is observable
   assign ram_out = ram[ram_address];
   always @(posedge CLK) begin
      if (!seeded) begin
         foreach (ram[i]) ram[i] <= 16'(16'hDEAD ^ i);
         seeded <= 1'b1;
      end else if (ram_load) ram[ram_address] <= ram_in;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // one clock cycle: check registered outputs, drive, check combinational outputs, advance model
   task automatic step(input logic rst, input logic r0, input logic w0, input logic [5:0] a0,
                       input logic [15:0] d0, input logic r1, input logic w1,
                       input logic [5:0] a1, input logic [15:0] d1);
      logic e0, e1;
      @(negedge CLK);
      chk("rdata0", rdata0, m_rd0);
      chk("rdata1", rdata1, m_rd1);
      reset = rst; req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      #1;
      e0 = 1'b0; e1 = 1'b0;
      if (rst) begin
         chk("busy_rst", busy, 1);
         chk("load_rst", ram_load, 0);
      end else if (m_clr > 0) begin
         chk("busy_clr", busy, 1);
         chk("load_clr", ram_load, 1);
         chk("clr_addr", ram_address, 64 - m_clr);
         chk("clr_in", ram_in, 0);
      end else begin
         if (r0 && r1) begin
            e0 = (m_last == 1'b1);
            e1 = (m_last == 1'b0);
         end else begin
            e0 = r0;
            e1 = r1;
         end
         chk("busy_arb", busy, 0);
         if (e0) begin
            chk("addr_g0", ram_address, a0); chk("in_g0", ram_in, d0); chk("load_g0", ram_load, w0);
         end else if (e1) begin
            chk("addr_g1", ram_address, a1); chk("in_g1", ram_in, d1); chk("load_g1", ram_load, w1);
         end else begin
            chk("addr_idle", ram_address, a0); chk("in_idle", ram_in, 0); chk("load_idle", ram_load, 0);
         end
      end
      chk("ack0", ack0, e0);
      chk("ack1", ack1, e1);
      s_ack0 = ack0;
      s_ack1 = ack1;
      if (rst) begin
         m_clr = 64; m_last = 1'b1; m_rd0 = '0; m_rd1 = '0;
      end else if (m_clr > 0) begin
         m_clr--;
         if (m_clr == 0) foreach (ref_mem[i]) ref_mem[i] = '0;
      end else if (e0) begin
         m_last = 1'b0;
         if (w0) ref_mem[a0] = d0; else m_rd0 = ref_mem[a0];
      end else if (e1) begin
         m_last = 1'b1;
         if (w1) ref_mem[a1] = d1; else m_rd1 = ref_mem[a1];
      end
   endtask

   task automatic idle(input logic rst);
      step(rst, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      tbl[0] = '{1,1,5,16'h1234, 0,0,0,0,      1,0, 16'h0000,16'hBEEF};
      tbl[1] = '{1,0,5,0,        0,0,0,0,      1,0, 16'h1234,16'hBEEF};
      tbl[2] = '{0,0,0,0,        0,0,0,0,      0,0, 16'h1234,16'hBEEF};
      tbl[3] = '{1,1,12,16'h5A5A,1,0,12,0,     0,1, 16'h1234,16'h0000};
      tbl[4] = '{1,1,12,16'h5A5A,0,0,0,0,      1,0, 16'h1234,16'h0000};
      tbl[5] = '{0,0,0,0,        1,0,12,0,     0,1, 16'h1234,16'h5A5A};
      tbl[6] = '{0,0,0,0,        1,1,63,16'hABCD,0,1,16'h1234,16'h5A5A};
      tbl[7] = '{1,0,63,0,       0,0,0,0,      1,0, 16'hABCD,16'h5A5A};
      tbl[8] = '{1,0,0,0,        0,0,0,0,      1,0, 16'h0000,16'h5A5A};
      tbl[9] = '{0,0,0,0,        1,0,5,0,      0,1, 16'h0000,16'h1234};
      m_clr = 64; m_last = 1'b1; m_rd0 = '0; m_rd1 = '0;
      foreach (ref_mem[i]) ref_mem[i] = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_busy", busy, 1);
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_load", ram_load, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      // clear sweep with both requesters already waiting on addr 10
      for (int k = 0; k < 64; k++) step(0, 1, 1, 10, 16'hBEEF, 1, 0, 10, 0);
      step(0, 1, 1, 10, 16'hBEEF, 1, 0, 10, 0);
      chk("first_arb_ack0", s_ack0, 1);
      step(0, 0, 0, 0, 0, 1, 0, 10, 0);
      chk("second_arb_ack1", s_ack1, 1);
      @(posedge CLK); #1;
      chk("rd1_new_data", rdata1, 16'hBEEF);
      for (int k = 0; k < 64; k++) begin
         step(0, 1, 0, 6'(k), 0, 0, 0, 0, 0);
         @(posedge CLK); #1;
         chk("clr_read", rdata0, (k == 10) ? 16'hBEEF : 16'h0000);
      end
      for (int k = 0; k < 10; k++) begin
         step(0, tbl[k].r0, tbl[k].w0, tbl[k].a0, tbl[k].d0, tbl[k].r1, tbl[k].w1, tbl[k].a1, tbl[k].d1);
         chk("tbl_ack0", s_ack0, tbl[k].x0);
         chk("tbl_ack1", s_ack1, tbl[k].x1);
         @(posedge CLK); #1;
         chk("tbl_rdata0", rdata0, tbl[k].q0);
         chk("tbl_rdata1", rdata1, tbl[k].q1);
      end
      for (int k = 0; k < 64; k++) step(0, 0, 0, 0, 0, 1, 1, 6'(k), 16'(k));
      for (int k = 0; k < 64; k++) begin
         step(0, 1, 0, 6'(k), 0, 0, 0, 0, 0);
         @(posedge CLK); #1;
         chk("sweep_read", rdata0, k);
      end
      // reset at clr_cnt = 20, then contention straight out of the clear
      idle(1);
      for (int k = 0; k < 20; k++) step(0, 1, 0, 3, 0, 1, 0, 4, 0);
      idle(1);
      for (int k = 0; k < 64; k++) step(0, 1, 1, 0, 0, 1, 0, 0, 0);
      i0 = 0;
      for (int k = 0; k < 20; k++) begin
         step(0, 1, 1, 6'(i0), 16'(i0), 1, 0, 0, 0);
         chk("alt_one_ack", s_ack0 ^ s_ack1, 1);
         chk("alt_order", s_ack0, (k % 2) == 0);
         if (s_ack0) i0++;
      end
      // reset mid-ARB wipes a fresh write
      step(0, 1, 1, 7, 16'h00FF, 0, 0, 0, 0);
      step(0, 1, 0, 7, 0, 0, 0, 0, 0);
      @(posedge CLK); #1;
      chk("rd7_before_rst", rdata0, 16'h00FF);
      idle(1);
      for (int k = 0; k < 64; k++) step(0, 1, 0, 7, 0, 0, 0, 0, 0);
      step(0, 1, 0, 7, 0, 0, 0, 0, 0);
      @(posedge CLK); #1;
      chk("rd7_after_rst", rdata0, 0);
      // randomized traffic with held requests and occasional reset
      for (int k = 0; k < 500; k++) begin
         if (!p0 && $urandom_range(0, 2) != 0) begin
            p0 = 1'b1; pw0 = 1'($urandom_range(0, 1));
            pa0 = $urandom_range(0, 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            pd0 = 16'($urandom);
         end
         if (!p1 && $urandom_range(0, 2) != 0) begin
            p1 = 1'b1; pw1 = 1'($urandom_range(0, 1));
            pa1 = $urandom_range(0, 1) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
            pd1 = 16'($urandom);
         end
         rr = ($urandom_range(0, 299) == 0);
         step(rr, p0, pw0, pa0, pd0, p1, pw1, pa1, pd1);
         if (rr) begin
            p0 = 1'b0; p1 = 1'b0;
         end else begin
            if (s_ack0) p0 = 1'b0;
            if (s_ack1) p1 = 1'b0;
         end
      end
      idle(0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
